// File: rtl/leve1_fetch.sv
// leve1_fetch: in-order fetch unit, 2-deep instruction queue, redirect handling.
// LEVE1_FETCH_BYPASS_EN: forward a response past an empty queue in the same cycle.
module leve1_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            CLK,
  input  logic            RSTn,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [31:0]     IMEM_RDATA,
  input  logic            FLUSH_VALID,
  input  logic [XLEN-1:0] FLUSH_PC,
  output logic            OVALID,
  output logic [XLEN-1:0] OPC,
  output logic [31:0]     OINSTR,
  input  logic            IREADY,
  output logic            IF_VALID,
  output logic            IF_READY,
  output logic [XLEN-1:0] IF_PC
);

  localparam logic [2:0]      CAP   = 3'(QDEPTH);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

  logic            req_q, req_d;
  logic            stale_q, stale_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  logic [XLEN-1:0] o_pc_q [2];
  logic [XLEN-1:0] o_pc_d [2];
  logic [1:0]      o_cnt_q, o_cnt_d;
  logic [1:0]      o_dsc_q, o_dsc_d;

  logic [XLEN-1:0] f_pc_q  [2];
  logic [XLEN-1:0] f_pc_d  [2];
  logic [31:0]     f_ins_q [2];
  logic [31:0]     f_ins_d [2];
  logic [1:0]      f_cnt_q, f_cnt_d;

  logic            flush, gnt_fire;
  logic            resp, resp_dsc, resp_ok;
  logic            push, push_ok, f_pop;
  logic [XLEN-1:0] resp_pc, fl_pc;
  logic [1:0]      f_cnt1, o_cnt1, o_dsc1;

  assign flush    = FLUSH_VALID;
  assign fl_pc    = FLUSH_PC & ALIGN;
  assign gnt_fire = req_q && IMEM_GNT;
  // responses with nothing outstanding belong to requests issued before reset
  assign resp     = IMEM_RVALID && (o_cnt_q != 2'd0);
  assign resp_dsc = flush || (o_dsc_q != 2'd0);
  assign resp_ok  = resp && !resp_dsc;
  assign resp_pc  = o_pc_q[0];
  assign f_pop    = IREADY && (f_cnt_q != 2'd0) && !flush;

`ifdef LEVE1_FETCH_BYPASS_EN
  logic byp;
  assign byp    = resp_ok && (f_cnt_q == 2'd0);
  assign OVALID = byp || (f_cnt_q != 2'd0);
  assign OPC    = byp ? resp_pc : f_pc_q[0];
  assign OINSTR = byp ? IMEM_RDATA : f_ins_q[0];
  assign push   = resp_ok && !(byp && IREADY);
`else
  assign OVALID = f_cnt_q != 2'd0;
  assign OPC    = f_pc_q[0];
  assign OINSTR = f_ins_q[0];
  assign push   = resp_ok;
`endif

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = fpc_q;
  assign IF_VALID  = OVALID;
  assign IF_READY  = IREADY;
  assign IF_PC     = OPC;

  always_comb begin
    f_pc_d  = f_pc_q;
    f_ins_d = f_ins_q;
    f_cnt1  = f_cnt_q - {1'b0, f_pop};
    if (f_pop) begin
      f_pc_d[0]  = f_pc_q[1];
      f_ins_d[0] = f_ins_q[1];
    end
    push_ok = push && (f_cnt1 != 2'd2);
    if (push_ok) begin
      f_pc_d[f_cnt1[0]]  = resp_pc;
      f_ins_d[f_cnt1[0]] = IMEM_RDATA;
    end
    f_cnt_d = flush ? 2'd0 : f_cnt1 + {1'b0, push_ok};

    o_pc_d = o_pc_q;
    o_cnt1 = o_cnt_q - {1'b0, resp};
    o_dsc1 = o_dsc_q - {1'b0, resp && (o_dsc_q != 2'd0)};
    if (resp) o_pc_d[0] = o_pc_q[1];
    if (gnt_fire && (o_cnt1 != 2'd2)) o_pc_d[o_cnt1[0]] = fpc_q;
    o_cnt_d = o_cnt1 + {1'b0, gnt_fire};
    o_dsc_d = flush ? o_cnt_d
                    : o_dsc1 + {1'b0, gnt_fire && stale_q};

    // a pending ungranted request keeps its address; target waits in tgt
    fpc_d   = fpc_q;
    tgt_d   = tgt_q;
    stale_d = stale_q;
    if (flush) begin
      if (req_q && !IMEM_GNT) begin
        stale_d = 1'b1;
        tgt_d   = fl_pc;
      end else begin
        stale_d = 1'b0;
        fpc_d   = fl_pc;
      end
    end else if (gnt_fire) begin
      stale_d = 1'b0;
      fpc_d   = stale_q ? tgt_q : fpc_q + XLEN'(4);
    end

    req_d = (req_q && !IMEM_GNT)
         || (!flush && (({1'b0, f_cnt_d} + {1'b0, o_cnt_d}) < CAP));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      req_q   <= 1'b0;
      stale_q <= 1'b0;
      fpc_q   <= RESET_PC & ALIGN;
      tgt_q   <= '0;
      o_cnt_q <= 2'd0;
      o_dsc_q <= 2'd0;
      f_cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        o_pc_q[i]  <= '0;
        f_pc_q[i]  <= '0;
        f_ins_q[i] <= '0;
      end
    end else begin
      req_q   <= req_d;
      stale_q <= stale_d;
      fpc_q   <= fpc_d;
      tgt_q   <= tgt_d;
      o_cnt_q <= o_cnt_d;
      o_dsc_q <= o_dsc_d;
      f_cnt_q <= f_cnt_d;
      o_pc_q  <= o_pc_d;
      f_pc_q  <= f_pc_d;
      f_ins_q <= f_ins_d;
    end
  end

  a_fifo_ovf: assert property (@(posedge CLK) disable iff (!RSTn)
    !(push && (f_cnt1 == 2'd2)));
  a_outs_ovf: assert property (@(posedge CLK) disable iff (!RSTn)
    !(gnt_fire && (o_cnt1 == 2'd2)));

endmodule

// File: tb/tb_leve1_fetch.sv
// tb_leve1_fetch: directed checks of leve1_fetch against an in-order memory.
// Memory returns data = addr[31:0] ^ 32'h5A5A5A5A.
module tb_leve1_fetch;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        IMEM_REQ;
  logic [63:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic        FLUSH_VALID = 1'b0;
  logic [63:0] FLUSH_PC = 64'h0;
  logic        OVALID;
  logic [63:0] OPC;
  logic [31:0] OINSTR;
  logic        IREADY = 1'b1;
  logic        IF_VALID;
  logic        IF_READY;
  logic [63:0] IF_PC;

  int errs = 0;
  int checks = 0;

  logic [63:0] q[$];
  logic [63:0] glog[$];
  logic [63:0] gaddr = 64'h0;
  logic        gnt_en = 1'b0;
  logic        rsp_en = 1'b0;
  logic        hold_en = 1'b0;
  logic [63:0] hold_addr = 64'h0;

  leve1_fetch dut (
    .CLK(CLK), .RSTn(RSTn),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA(IMEM_RDATA),
    .FLUSH_VALID(FLUSH_VALID), .FLUSH_PC(FLUSH_PC),
    .OVALID(OVALID), .OPC(OPC), .OINSTR(OINSTR),
    .IREADY(IREADY),
    .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_PC(IF_PC)
  );

  always #5 CLK = ~CLK;

  // in-order memory: grants/returns are decided just after each edge
  always @(posedge CLK) begin
    if (IMEM_RVALID && q.size() > 0) void'(q.pop_front());
    if (IMEM_GNT && RSTn) begin
      q.push_back(gaddr);
      glog.push_back(gaddr);
    end
    #1;
    IMEM_GNT = gnt_en && IMEM_REQ
            && !(hold_en && IMEM_ADDR == hold_addr);
    gaddr = IMEM_ADDR;
    IMEM_RVALID = rsp_en && q.size() > 0;
    IMEM_RDATA = (q.size() > 0) ? (q[0][31:0] ^ 32'h5A5A5A5A) : 32'h0;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_head(input string tag, input logic [63:0] pc,
                           input logic [31:0] ins);
    int n = 0;
    while (!OVALID && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_v"}, 64'(IF_VALID), 64'd1);
    chk({tag, "_pc"}, OPC, pc);
    chk({tag, "_ifpc"}, IF_PC, pc);
    chk({tag, "_ins"}, 64'(OINSTR), 64'(ins));
    @(negedge CLK);
  endtask

  task automatic wait_outs2(input string tag);
    int n = 0;
    while (q.size() != 2 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 64'(q.size()), 64'd2);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    chk("rst_req", 64'(IMEM_REQ), 64'd0);
    chk("rst_ovalid", 64'(OVALID), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("req_first_edge", 64'(IMEM_REQ), 64'd1);
    chk("addr_reset_pc", IMEM_ADDR, 64'h8000_0000);

    // streaming fetch
    gnt_en = 1'b1;
    rsp_en = 1'b1;
    wait_head("h0", 64'h8000_0000, 32'hDA5A_5A5A);
    chk("if_ready", 64'(IF_READY), 64'd1);
    wait_head("h1", 64'h8000_0004, 32'hDA5A_5A5E);
    wait_head("h2", 64'h8000_0008, 32'hDA5A_5A52);
    chk("gaddr0", glog[0], 64'h8000_0000);
    chk("gaddr1", glog[1], 64'h8000_0004);
    chk("gaddr2", glog[2], 64'h8000_0008);

    // decode stall: queue fills to 2, request stops, order kept
    IREADY = 1'b0;
    FLUSH_VALID = 1'b1;
    FLUSH_PC = 64'h8000_0200;
    @(negedge CLK);
    FLUSH_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    chk("hold_req", 64'(IMEM_REQ), 64'd0);
    chk("hold_ovalid", 64'(OVALID), 64'd1);
    chk("hold_outs", 64'(q.size()), 64'd0);
    chk("hold_pc0", OPC, 64'h8000_0200);
    IREADY = 1'b1;
    @(negedge CLK);
    chk("rel_v1", 64'(OVALID), 64'd1);
    chk("rel_pc1", OPC, 64'h8000_0204);
    @(negedge CLK);
    wait_head("rel2", 64'h8000_0208, 32'hDA5A_5852);

    // flush with two outstanding, one response inside the flush cycle
    rsp_en = 1'b0;
    wait_outs2("fl_outs2");
    repeat (2) @(negedge CLK);
    chk("fl_req_off", 64'(IMEM_REQ), 64'd0);
    chk("fl_ov_empty", 64'(OVALID), 64'd0);
    rsp_en = 1'b1;
    @(negedge CLK);
    FLUSH_VALID = 1'b1;
    FLUSH_PC = 64'h8000_0100;
    @(negedge CLK);
    FLUSH_VALID = 1'b0;
    wait_head("fl", 64'h8000_0100, 32'hDA5A_5B5A);

    // reset mid-burst; late responses must be dropped
    rsp_en = 1'b0;
    wait_outs2("rst_outs2");
    RSTn = 1'b0;
    @(negedge CLK);
    chk("rst2_req", 64'(IMEM_REQ), 64'd0);
    chk("rst2_ovalid", 64'(OVALID), 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    gnt_en = 1'b0;
    rsp_en = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      chk("stale_ovalid", 64'(OVALID), 64'd0);
      @(negedge CLK);
      n++;
    end
    chk("stale_ovalid_end", 64'(OVALID), 64'd0);
    chk("stale_drained", 64'(q.size()), 64'd0);
    chk("rst2_req_on", 64'(IMEM_REQ), 64'd1);
    chk("rst2_addr", IMEM_ADDR, 64'h8000_0000);

    // double flush during an ungranted request, misaligned last target
    hold_addr = 64'h8000_0008;
    hold_en = 1'b1;
    gnt_en = 1'b1;
    wait_head("r0", 64'h8000_0000, 32'hDA5A_5A5A);
    wait_head("r1", 64'h8000_0004, 32'hDA5A_5A5E);
    n = 0;
    while (!(IMEM_REQ && IMEM_ADDR == 64'h8000_0008) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("pend_req", 64'(IMEM_REQ), 64'd1);
    FLUSH_VALID = 1'b1;
    FLUSH_PC = 64'h8000_0500;
    @(negedge CLK);
    FLUSH_PC = 64'h8000_0103;
    @(negedge CLK);
    FLUSH_VALID = 1'b0;
    @(negedge CLK);
    chk("pend_req_kept", 64'(IMEM_REQ), 64'd1);
    chk("pend_addr_kept", IMEM_ADDR, 64'h8000_0008);
    hold_en = 1'b0;
    n = 0;
    while (!(IMEM_REQ && IMEM_ADDR != 64'h8000_0008) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("redir_addr", IMEM_ADDR, 64'h8000_0100);
    wait_head("redir", 64'h8000_0100, 32'hDA5A_5B5A);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
